sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the CPU core's instruction-fetch requester and its load/store requester. It sits between the core's inst/data request interfaces and the downstream bridge or memory. It allows one outstanding transaction at a time, gives data requests priority, and includes a starvation guard for fetch. Responses are routed back to the requester that owns the current transaction.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants, while an inst request waits, after which inst is forced to win; range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / data_req  in  1  request valid; the requester holds it and its payload stable until the matching *_addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  32  byte address
- inst_wstrb / data_wstrb  in  4  byte write strobes
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted (one-cycle pulse)
- inst_data_ok / data_data_ok  out  1  response complete (one-cycle pulse)
- inst_rdata / data_rdata  out  32  read data, valid with *_data_ok
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  downstream payload
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response done
- mem_rdata  in  32  downstream read data
- arb_busy  out  1  1 when state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: state, owner (0 = inst, 1 = data), starve_cnt (4 bits).
- IDLE:
  - If neither requester asserts req, stay in IDLE.
  - Otherwise select the owner and go to REQ:
    - Only inst requests: owner = inst.
    - Only data requests: owner = data.
    - Both request: owner = inst if starve_cnt == STARVE_LIMIT, else owner = data.
- starve_cnt is updated on the IDLE→REQ transition:
  - Data granted while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - Inst granted: clear to 0.
  - Data granted with inst_req = 0: hold.
- REQ:
  - mem_req = 1.
  - mem_wr/size/addr/wstrb/wdata are driven combinationally from the owner's inputs.
  - owner_addr_ok = mem_addr_ok.
  - On mem_addr_ok, go to WAIT.
- WAIT:
  - mem_req = 0.
  - owner_data_ok = mem_data_ok.
  - On mem_data_ok, go to IDLE.
- inst_rdata and data_rdata both equal mem_rdata, combinationally. Only the owner's data_ok qualifies the data.
- The non-owner's addr_ok and data_ok are always 0.
- Outside REQ, mem_* payload outputs are 0.
- mem_data_ok outside WAIT is ignored; a bench assertion flags it.
- mem_addr_ok outside REQ is ignored.
- A requester dropping req while in REQ is a protocol violation. The arbiter keeps mem_req asserted regardless.
- No flush input. The core discards unwanted responses itself; every granted transaction completes.
- Reset (resetn = 0, asynchronous):
  - State registers: state = IDLE, owner = 0, starve_cnt = 0.
  - Outputs: mem_req = 0, all *_addr_ok = 0, all *_data_ok = 0, arb_busy = 0.
  - Reset mid-transaction abandons it; the downstream side is reset together with the arbiter.

## Timing
- Arbitration latency is 1 cycle: req sampled in IDLE at edge t gives mem_req = 1 from cycle t+1.
- addr_ok follows mem_addr_ok combinationally. It is earliest in cycle t+1.
- data_ok follows mem_data_ok combinationally. It is earliest in cycle t+2, because the downstream port never returns data_ok in the addr_ok cycle.
- After data_ok the FSM re-enters IDLE. The next grant's mem_req is earliest 2 cycles after the previous data_ok cycle.
- Minimum transaction period is 3 cycles.
- Simultaneous inst_req and data_req are resolved only in IDLE. A request arriving during REQ/WAIT waits for IDLE.
- Owner and payload are stable for the whole REQ phase. mem_* outputs are glitch-free relative to the clk edge, given stable inputs.

## Test plan
- Single inst read:
  - Stimulus: inst_req = 1, addr = 0x1c000000; mem_addr_ok in cycle 1; mem_data_ok in cycle 3 with mem_rdata = 0x02800404.
  - Required: mem_req high in cycles 1 only; inst_addr_ok pulse in cycle 1; inst_data_ok pulse in cycle 3 with inst_rdata = 0x02800404; data_* never pulses.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (write, addr 0x100, wstrb = 4'b0011, wdata = 0xABCD1234) rise together.
  - Required: data served first with mem_wstrb = 0011; inst granted on the next IDLE; starve_cnt = 1 after the first grant.
- Starvation guard, STARVE_LIMIT = 4:
  - Stimulus: both requesters held continuously.
  - Required: grant order D, D, D, D, I, D…; starve_cnt clears to 0 on the inst grant.
- Slow downstream:
  - Stimulus: mem_addr_ok delayed 5 cycles and mem_data_ok delayed 7 cycles.
  - Required: mem_req held with a stable payload; no duplicate addr_ok; exactly one data_ok.
- Reset mid-WAIT:
  - Stimulus: resetn = 0 while in WAIT.
  - Required: arb_busy = 0 and all outputs at reset values immediately (asynchronous), before the next clk edge; after release, a new inst request completes normally.
- Spurious mem_data_ok in IDLE:
  - Required: no *_data_ok pulse; state stays IDLE.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like memory port between the fetch
// and load/store requesters, one transaction at a time.
// Ports: clk, resetn (async, active-low); inst_* / data_* request and
// response channels; mem_* downstream port; arb_busy while not idle.
// Data requests win ties unless fetch has waited STARVE_LIMIT data grants.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       grant_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Fetch only wins a tie once it has been passed over LIM times.
  assign grant_data = data_req && !(inst_req && starve_q == LIM);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          state_d = REQ;
          owner_d = grant_data;
          if (!grant_data) begin
            starve_d = 4'd0;
          end else if (inst_req && starve_q != LIM) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_req;
  logic in_wait;

  always_comb begin
    in_req       = (state_q == REQ);
    in_wait      = (state_q == WAIT);
    mem_req      = in_req;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = 32'd0;
    mem_wstrb    = 4'd0;
    mem_wdata    = 32'd0;
    if (in_req) begin
      if (owner_q) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
    end
    inst_addr_ok = in_req  && !owner_q && mem_addr_ok;
    data_addr_ok = in_req  &&  owner_q && mem_addr_ok;
    inst_data_ok = in_wait && !owner_q && mem_data_ok;
    data_data_ok = in_wait &&  owner_q && mem_data_ok;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    arb_busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model.
module tb_sram_like_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        arb_busy;

  int passed = 0;
  int total  = 0;

  sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: phase of the single outstanding
  // transaction (0 none, 1 awaiting acceptance, 2 awaiting response),
  // who owns it, and how many data grants fetch has sat through.
  int m_phase = 0;
  int m_owner = 0;
  int m_starve = 0;
  bit m_iacc, m_dacc;
  int m_grants[$];

  always @(negedge resetn) begin
    m_phase = 0; m_owner = 0; m_starve = 0;
  end

  always @(posedge clk) begin
    m_iacc = 0;
    m_dacc = 0;
    if (!resetn) begin
      m_phase = 0; m_owner = 0; m_starve = 0;
    end else if (m_phase == 0) begin
      if (inst_req || data_req) begin
        if (data_req && !(inst_req && m_starve == LIMIT)) begin
          m_owner = 1;
          if (inst_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end else begin
          m_owner = 0;
          m_starve = 0;
        end
        m_grants.push_back(m_owner);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_addr_ok) begin
        m_iacc = (m_owner == 0);
        m_dacc = (m_owner == 1);
        m_phase = 2;
      end
    end else begin
      if (mem_data_ok) m_phase = 0;
    end
  end

  logic [140:0] exp_v, act_v;

  always @(negedge clk) begin
    if (resetn) begin
      logic [71:0] pay;
      pay = '0;
      if (m_phase == 1) begin
        pay = (m_owner == 1) ?
          {1'b1, data_wr, data_size, data_addr, data_wstrb, data_wdata} :
          {1'b1, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
      end
      exp_v = {pay,
               m_phase == 1 && m_owner == 0 && mem_addr_ok,
               m_phase == 1 && m_owner == 1 && mem_addr_ok,
               m_phase == 2 && m_owner == 0 && mem_data_ok,
               m_phase == 2 && m_owner == 1 && mem_data_ok,
               m_phase != 0, mem_rdata, mem_rdata};
      act_v = {mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
               inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
               arb_busy, inst_rdata, data_rdata};
      total++;
      if (act_v === exp_v) passed++;
      else $display("FAIL cycle_cmp t=%0t got %h exp %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_wstrb;
  logic        snap_wr;

  // Runs one transaction from an idle arbiter with requests already set.
  task automatic txn(input int ad, input int dd, input logic [31:0] rd,
                     input bit hold, input bit drop_all, output int who);
    logic [31:0] a0;
    who = -1;
    a0 = '0;
    cyc();
    for (int n = 0; n <= ad; n++) begin
      if (n == ad) mem_addr_ok = 1'b1;
      @(negedge clk);
      chk("req_held", 32'(mem_req), 32'd1);
      if (n == 0) begin
        a0 = mem_addr;
        snap_addr = mem_addr; snap_wdata = mem_wdata;
        snap_wstrb = mem_wstrb; snap_wr = mem_wr;
      end else begin
        chk("addr_stable", mem_addr, a0);
      end
      if (n < ad) chk("no_early_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      else if (inst_addr_ok && !data_addr_ok) who = 0;
      else if (data_addr_ok && !inst_addr_ok) who = 1;
      cyc();
    end
    mem_addr_ok = 1'b0;
    if (!hold) begin
      if (who == 0) inst_req = 1'b0;
      if (who == 1) data_req = 1'b0;
    end
    for (int n = 0; n <= dd; n++) begin
      if (n == dd) begin
        mem_data_ok = 1'b1;
        mem_rdata = rd;
        if (drop_all) begin inst_req = 1'b0; data_req = 1'b0; end
      end
      @(negedge clk);
      chk("wait_no_mem_req", 32'(mem_req), 32'd0);
      if (n < dd) begin
        chk("no_early_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("no_dup_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end else begin
        chk("dok_owner", 32'({inst_data_ok, data_data_ok}),
            (who == 0) ? 32'd2 : 32'd1);
        chk("rdata", (who == 0) ? inst_rdata : data_rdata, rd);
      end
      cyc();
    end
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(arb_busy), 32'd0);
    chk("no_dup_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
  endtask

  int who;
  int ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    resetn = 1'b0;
    {inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata} = '0;
    {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} = '0;
    {mem_addr_ok, mem_data_ok, mem_rdata} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    resetn = 1'b1;
    cyc();

    // single fetch read
    inst_req = 1'b1; inst_addr = 32'h1c000000; inst_size = 2'd2;
    txn(0, 1, 32'h02800404, 1'b0, 1'b0, who);
    chk("single_owner", 32'(who), 32'd0);
    chk("single_addr", snap_addr, 32'h1c000000);

    // simultaneous: data first, fetch next
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100;
    data_wstrb = 4'b0011; data_wdata = 32'hABCD1234; data_size = 2'd2;
    txn(0, 0, 32'h0, 1'b0, 1'b0, who);
    chk("sim_first_data", 32'(who), 32'd1);
    chk("sim_wstrb", 32'(snap_wstrb), 32'd3);
    chk("sim_wdata", snap_wdata, 32'hABCD1234);
    chk("sim_wr", 32'(snap_wr), 32'd1);
    chk("sim_starve", 32'(m_starve), 32'd1);
    txn(0, 0, 32'h11112222, 1'b0, 1'b0, who);
    chk("sim_then_inst", 32'(who), 32'd0);

    // starvation guard with both held
    cyc();
    m_grants.delete();
    inst_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      txn(0, 0, 32'(k), 1'b1, k == 9, who);
      chk("starve_order", 32'(who), 32'(ord[k]));
    end
    for (int k = 0; k < 10; k++)
      chk("model_order", 32'(m_grants[k]), 32'(ord[k]));
    chk("starve_cleared", 32'(m_starve), 32'd0);

    // slow downstream
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1c000040;
    txn(5, 7, 32'hDEADBEEF, 1'b0, 1'b0, who);
    chk("slow_owner", 32'(who), 32'd0);

    // spurious responses while idle
    cyc();
    mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("spur_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    cyc();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("spur_idle", 32'(arb_busy), 32'd0);

    // reset while waiting for the response
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1c000080;
    cyc();
    mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0; inst_req = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk("pre_rst_dok", 32'(inst_data_ok), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_busy", 32'(arb_busy), 32'd0);
    chk("async_dok", 32'(inst_data_ok), 32'd0);
    chk("async_mem_req", 32'(mem_req), 32'd0);
    cyc();
    mem_data_ok = 1'b0;
    cyc();
    resetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1c0000c0;
    txn(1, 2, 32'h13572468, 1'b0, 1'b0, who);
    chk("post_rst_owner", 32'(who), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i == 1500) resetn = 1'b0;
      if (i == 1502) resetn = 1'b1;
      if (m_iacc || !inst_req) begin
        inst_req = ($urandom_range(2) == 0);
        inst_wr = 1'(($urandom));
        inst_size = 2'($urandom_range(2));
        inst_addr = $urandom; inst_wstrb = 4'($urandom);
        inst_wdata = $urandom;
      end
      if (m_dacc || !data_req) begin
        data_req = ($urandom_range(2) == 0);
        data_wr = 1'(($urandom));
        data_size = 2'($urandom_range(2));
        data_addr = $urandom; data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      mem_rdata = $urandom;
      mem_addr_ok = (m_phase == 1) ? ($urandom_range(2) == 0)
                                   : ($urandom_range(15) == 0);
      mem_data_ok = (m_phase == 2) ? ($urandom_range(2) == 0) :
                    (m_phase == 0) ? ($urandom_range(15) == 0) : 1'b0;
    end
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
